// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller.
// Holds the FSM state enum, RV32I major opcodes, ALU mux/op encodings and
// the packed control word driven onto the datapath.
package mc_ctrl_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [3:0] {
    ST_IF      = 4'd0,
    ST_ID      = 4'd1,
    ST_EX_R    = 4'd2,
    ST_EX_I    = 4'd3,
    ST_EX_ADDR = 4'd4,
    ST_EX_JALR = 4'd5,
    ST_EX_BR   = 4'd6,
    ST_MEM_RD  = 4'd7,
    ST_MEM_WR  = 4'd8,
    ST_WB_ALU  = 4'd9,
    ST_WB_MEM  = 4'd10,
    ST_JAL     = 4'd11,
    ST_PC4     = 4'd12,
    ST_HALT    = 4'd13
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_FUNCT  = 2'b01;
  localparam logic [1:0] ALU_BRANCH = 2'b10;

  // Full set of datapath controls produced each cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op_sel;
    logic       is_halted;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_perf_counters.sv
// Performance counters for the multi-cycle controller (built only when
// MC_CTRL_PERF_CNT_EN is defined).
// Ports: clk, reset (sync, active-low), count_cycle / count_retire
// increment strobes, cycle_count / retire_count wrapping 32-bit counts.
module mc_ctrl_perf_counters
  import mc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             count_cycle,
  input  logic             count_retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  // Free-running wrap-around counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      if (count_cycle)  cycle_count  <= cycle_count + CNT_W'(1);
      if (count_retire) retire_count <= retire_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/
// write-back over a shared ALU and unified memory port.
// Inputs : clk, reset (sync, active-low), opcode, alu_bcond, ecall_halt,
//          mem_ready.
// Outputs: datapath selects/enables, is_halted, cycle_count, retire_count.
// Build option: MC_CTRL_PERF_CNT_EN enables the performance counters;
// without it both counter ports read 0.
module multi_cycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             alu_bcond,
  input  logic             ecall_halt,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op_sel,
  output logic             is_halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_c;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IF;
    else        state_q <= state_d;
  end

  // Next-state and control decode; everything is forced low while in reset.
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      ST_IF: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.ir_write = mem_ready;
        if (mem_ready) state_d = ST_ID;
      end
      ST_ID: begin
        // ALUOut <= PC + imm, used later as branch/JAL target.
        ctrl_c.alu_src_b  = SRC_B_IMM;
        ctrl_c.alu_op_sel = ALU_ADD;
        case (opcode)
          OP_R:               state_d = ST_EX_R;
          OP_IMM:             state_d = ST_EX_I;
          OP_LOAD, OP_STORE:  state_d = ST_EX_ADDR;
          OP_BRANCH:          state_d = ST_EX_BR;
          OP_JAL:             state_d = ST_JAL;
          OP_JALR:            state_d = ST_EX_JALR;
          OP_SYSTEM:          state_d = ecall_halt ? ST_HALT : ST_PC4;
          default:            state_d = ST_PC4;
        endcase
      end
      ST_EX_R: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRC_B_REG;
        ctrl_c.alu_op_sel = ALU_FUNCT;
        state_d           = ST_WB_ALU;
      end
      ST_EX_I: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRC_B_IMM;
        ctrl_c.alu_op_sel = ALU_FUNCT;
        state_d           = ST_WB_ALU;
      end
      ST_EX_ADDR: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRC_B_IMM;
        ctrl_c.alu_op_sel = ALU_ADD;
        state_d           = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_EX_JALR: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRC_B_IMM;
        ctrl_c.alu_op_sel = ALU_ADD;
        state_d           = ST_JAL;
      end
      ST_EX_BR: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRC_B_REG;
        ctrl_c.alu_op_sel = ALU_BRANCH;
        if (alu_bcond) begin
          ctrl_c.pc_write = 1'b1;
          ctrl_c.pc_src   = 1'b1;
          state_d         = ST_IF;
        end else begin
          state_d = ST_PC4;
        end
      end
      ST_MEM_RD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
        if (mem_ready) state_d = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        // Store retires here, so PC+4 is taken the cycle the write lands.
        ctrl_c.mem_write  = 1'b1;
        ctrl_c.i_or_d     = 1'b1;
        ctrl_c.alu_src_b  = SRC_B_FOUR;
        ctrl_c.alu_op_sel = ALU_ADD;
        ctrl_c.pc_write   = mem_ready;
        if (mem_ready) state_d = ST_IF;
      end
      ST_WB_ALU, ST_WB_MEM: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = (state_q == ST_WB_MEM);
        ctrl_c.alu_src_b  = SRC_B_FOUR;
        ctrl_c.alu_op_sel = ALU_ADD;
        ctrl_c.pc_write   = 1'b1;
        state_d           = ST_IF;
      end
      ST_JAL: begin
        // rd <= PC+4 from the ALU while PC loads the target held in ALUOut.
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.pc_to_reg  = 1'b1;
        ctrl_c.alu_src_b  = SRC_B_FOUR;
        ctrl_c.alu_op_sel = ALU_ADD;
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.pc_src     = 1'b1;
        state_d           = ST_IF;
      end
      ST_PC4: begin
        ctrl_c.alu_src_b  = SRC_B_FOUR;
        ctrl_c.alu_op_sel = ALU_ADD;
        ctrl_c.pc_write   = 1'b1;
        state_d           = ST_IF;
      end
      ST_HALT: begin
        ctrl_c.is_halted = 1'b1;
        state_d          = ST_HALT;
      end
      default: state_d = ST_IF;
    endcase
    if (!reset) ctrl_c = '0;
  end

  assign pc_write   = ctrl_c.pc_write;
  assign pc_src     = ctrl_c.pc_src;
  assign i_or_d     = ctrl_c.i_or_d;
  assign mem_read   = ctrl_c.mem_read;
  assign mem_write  = ctrl_c.mem_write;
  assign ir_write   = ctrl_c.ir_write;
  assign reg_write  = ctrl_c.reg_write;
  assign mem_to_reg = ctrl_c.mem_to_reg;
  assign pc_to_reg  = ctrl_c.pc_to_reg;
  assign alu_src_a  = ctrl_c.alu_src_a;
  assign alu_src_b  = ctrl_c.alu_src_b;
  assign alu_op_sel = ctrl_c.alu_op_sel;
  assign is_halted  = ctrl_c.is_halted;

`ifdef MC_CTRL_PERF_CNT_EN
  logic             enter_halt;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] retire_q;

  // The ECALL that halts has no pc_write, so it retires on HALT entry.
  assign enter_halt = (state_q == ST_ID) && (state_d == ST_HALT);

  mc_ctrl_perf_counters u_perf (
    .clk          (clk),
    .reset        (reset),
    .count_cycle  (state_q != ST_HALT),
    .count_retire (ctrl_c.pc_write | enter_halt),
    .cycle_count  (cycle_q),
    .retire_count (retire_q)
  );

  assign cycle_count  = reset ? cycle_q  : '0;
  assign retire_count = reset ? retire_q : '0;
`else
  assign cycle_count  = '0;
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: instruction-level model
// of expected control words per cycle, a tiny PC/ALUOut datapath and
// hand-computed PC expectations.
`timescale 1ns/1ps
module tb_multi_cycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = 7'h00;
  logic        alu_bcond = 1'b0;
  logic        ecall_halt = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_write, mem_to_reg, pc_to_reg, alu_src_a, is_halted;
  logic [1:0]  alu_src_b, alu_op_sel;
  logic [31:0] cycle_count, retire_count;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond),
    .ecall_halt(ecall_halt), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
    .is_halted(is_halted), .cycle_count(cycle_count),
    .retire_count(retire_count)
  );

  typedef struct packed {
    logic       pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, mem_to_reg, pc_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op_sel;
    logic       is_halted;
  } cw_t;

  cw_t dut_cw;
  assign dut_cw = {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
                   reg_write, mem_to_reg, pc_to_reg, alu_src_a, alu_src_b,
                   alu_op_sel, is_halted};

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_ECALL = 7, K_NOP = 8;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          dut_pcw = 0;
  logic [31:0] exp_cycle = 0;
  logic [31:0] exp_retire = 0;

  // Minimal PC / ALUOut datapath steered by the DUT's selects.
  logic [31:0] pc_m = 0, aluout_m = 0;
  logic [31:0] dp_a = 0, dp_b = 0, dp_imm = 0, dp_init = 0;
  logic        dp_load = 1'b0;
  logic [31:0] alu_x, alu_y, alu_r;

  always_comb begin
    alu_x = alu_src_a ? dp_a : pc_m;
    case (alu_src_b)
      2'b00:   alu_y = dp_b;
      2'b01:   alu_y = 32'd4;
      2'b10:   alu_y = dp_imm;
      default: alu_y = 32'd0;
    endcase
    alu_r = (alu_op_sel == 2'b00) ? alu_x + alu_y : alu_x - alu_y;
  end

  always @(posedge clk) begin
    aluout_m <= alu_r;
    if (dp_load)       pc_m <= dp_init;
    else if (pc_write) pc_m <= pc_src ? {aluout_m[31:1], 1'b0} : alu_r;
  end

  // Expected control words, one per instruction phase.
  function automatic cw_t w_fetch(input logic mr);
    cw_t w = '0; w.mem_read = 1'b1; w.ir_write = mr; return w;
  endfunction
  function automatic cw_t w_decode();
    cw_t w = '0; w.alu_src_b = 2'b10; return w;
  endfunction
  function automatic cw_t w_exec(input logic [1:0] b, input logic [1:0] op);
    cw_t w = '0; w.alu_src_a = 1'b1; w.alu_src_b = b; w.alu_op_sel = op; return w;
  endfunction
  function automatic cw_t w_ex_br(input logic bc);
    cw_t w = w_exec(2'b00, 2'b10); w.pc_write = bc; w.pc_src = bc; return w;
  endfunction
  function automatic cw_t w_mem_rd();
    cw_t w = '0; w.mem_read = 1'b1; w.i_or_d = 1'b1; return w;
  endfunction
  function automatic cw_t w_mem_wr(input logic mr);
    cw_t w = '0; w.mem_write = 1'b1; w.i_or_d = 1'b1; w.alu_src_b = 2'b01;
    w.pc_write = mr; return w;
  endfunction
  function automatic cw_t w_pc4();
    cw_t w = '0; w.alu_src_b = 2'b01; w.pc_write = 1'b1; return w;
  endfunction
  function automatic cw_t w_wb(input logic m);
    cw_t w = w_pc4(); w.reg_write = 1'b1; w.mem_to_reg = m; return w;
  endfunction
  function automatic cw_t w_jal();
    cw_t w = w_pc4(); w.reg_write = 1'b1; w.pc_to_reg = 1'b1; w.pc_src = 1'b1;
    return w;
  endfunction
  function automatic cw_t w_halt();
    cw_t w = '0; w.is_halted = 1'b1; return w;
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive mem_ready, compare at negedge, advance counter model.
  task automatic cyc(input string name, input cw_t e, input logic mr, input logic enter_halt);
    mem_ready = mr;
    if (!reset) begin exp_cycle = 0; exp_retire = 0; end
    @(negedge clk);
    check({name, " ctrl"}, 32'(dut_cw), 32'(e));
`ifdef MC_CTRL_PERF_CNT_EN
    check({name, " cycle_count"}, cycle_count, exp_cycle);
    check({name, " retire_count"}, retire_count, exp_retire);
`else
    check({name, " cycle_count"}, cycle_count, 32'd0);
    check({name, " retire_count"}, retire_count, 32'd0);
`endif
    if (pc_write === 1'b1) dut_pcw++;
    @(posedge clk);
    if (reset) begin
      if (!e.is_halted) exp_cycle++;
      if (e.pc_write || enter_halt) exp_retire++;
    end
    #1;
    dp_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc("reset", '0, rb(), 1'b0);
    reset = 1'b1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    dp_init = v; dp_load = 1'b1;
  endtask

  function automatic logic [6:0] op_of(input int k);
    case (k)
      K_R:     return 7'h33;
      K_I:     return 7'h13;
      K_LD:    return 7'h03;
      K_ST:    return 7'h23;
      K_BR:    return 7'h63;
      K_JAL:   return 7'h6F;
      K_JALR:  return 7'h67;
      K_ECALL: return 7'h73;
      default: return 7'h0F;
    endcase
  endfunction

  task automatic run_instr(input string name, input int kind, input int if_w,
                           input int mem_w, input logic bc, input logic eh,
                           input logic [31:0] exp_pc);
    logic halting;
    halting = (kind == K_ECALL) && eh;
    opcode = op_of(kind); alu_bcond = bc; ecall_halt = eh; dut_pcw = 0;
    for (int i = 0; i < if_w; i++) cyc({name, " IF wait"}, w_fetch(1'b0), 1'b0, 1'b0);
    cyc({name, " IF"}, w_fetch(1'b1), 1'b1, 1'b0);
    cyc({name, " ID"}, w_decode(), rb(), halting);
    case (kind)
      K_R: begin
        cyc({name, " EX"}, w_exec(2'b00, 2'b01), rb(), 1'b0);
        cyc({name, " WB"}, w_wb(1'b0), rb(), 1'b0);
      end
      K_I: begin
        cyc({name, " EX"}, w_exec(2'b10, 2'b01), rb(), 1'b0);
        cyc({name, " WB"}, w_wb(1'b0), rb(), 1'b0);
      end
      K_LD: begin
        cyc({name, " EX"}, w_exec(2'b10, 2'b00), rb(), 1'b0);
        for (int i = 0; i < mem_w; i++) cyc({name, " MEM wait"}, w_mem_rd(), 1'b0, 1'b0);
        cyc({name, " MEM"}, w_mem_rd(), 1'b1, 1'b0);
        cyc({name, " WB"}, w_wb(1'b1), rb(), 1'b0);
      end
      K_ST: begin
        cyc({name, " EX"}, w_exec(2'b10, 2'b00), rb(), 1'b0);
        for (int i = 0; i < mem_w; i++) cyc({name, " MEM wait"}, w_mem_wr(1'b0), 1'b0, 1'b0);
        cyc({name, " MEM"}, w_mem_wr(1'b1), 1'b1, 1'b0);
      end
      K_BR: begin
        cyc({name, " EX"}, w_ex_br(bc), rb(), 1'b0);
        if (!bc) cyc({name, " PC4"}, w_pc4(), rb(), 1'b0);
      end
      K_JAL: cyc({name, " JAL"}, w_jal(), rb(), 1'b0);
      K_JALR: begin
        cyc({name, " EX"}, w_exec(2'b10, 2'b00), rb(), 1'b0);
        cyc({name, " JAL"}, w_jal(), rb(), 1'b0);
      end
      default: if (!halting) cyc({name, " PC4"}, w_pc4(), rb(), 1'b0);
    endcase
    if (!halting) check({name, " pc_write pulses"}, 32'(dut_pcw), 32'd1);
    check({name, " pc"}, pc_m, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    do_reset();
    dp_a = 32'h0000_0101; dp_b = 32'h0000_0007; dp_imm = 32'h0000_0010;
    set_pc(32'h0);
    run_instr("ADD",      K_R,  0, 0, 1'b0, 1'b0, 32'h04);
    run_instr("ADD ifw",  K_R,  1, 0, 1'b0, 1'b0, 32'h08);
    run_instr("ADDI",     K_I,  0, 0, 1'b0, 1'b0, 32'h0C);
    run_instr("LW",       K_LD, 0, 2, 1'b0, 1'b0, 32'h10);
    run_instr("SW",       K_ST, 1, 1, 1'b0, 1'b0, 32'h14);
    set_pc(32'h10); dp_imm = 32'hFFFF_FFF8;
    run_instr("BEQ taken", K_BR, 0, 0, 1'b1, 1'b0, 32'h08);
    set_pc(32'h10);
    run_instr("BEQ not",   K_BR, 0, 0, 1'b0, 1'b0, 32'h14);
    set_pc(32'h20); dp_imm = 32'h40;
    run_instr("JAL",       K_JAL, 0, 0, 1'b0, 1'b0, 32'h60);
    dp_imm = 32'h4;
    run_instr("JALR",      K_JALR, 0, 0, 1'b0, 1'b0, 32'h104);
    run_instr("ECALL",     K_ECALL, 0, 0, 1'b0, 1'b0, 32'h108);
    run_instr("NOP",       K_NOP, 0, 0, 1'b0, 1'b0, 32'h10C);

    // Reset while a store waits on memory: no PC update, back to fetch.
    opcode = 7'h23; dut_pcw = 0;
    cyc("SWabort IF", w_fetch(1'b1), 1'b1, 1'b0);
    cyc("SWabort ID", w_decode(), rb(), 1'b0);
    cyc("SWabort EX", w_exec(2'b10, 2'b00), rb(), 1'b0);
    cyc("SWabort MEM wait", w_mem_wr(1'b0), 1'b0, 1'b0);
    cyc("SWabort MEM wait", w_mem_wr(1'b0), 1'b0, 1'b0);
    reset = 1'b0;
    cyc("reset in MEM_WR", '0, 1'b1, 1'b0);
    reset = 1'b1;
    check("SWabort pc_write pulses", 32'(dut_pcw), 32'd0);
    check("SWabort pc", pc_m, 32'h10C);
    run_instr("ADD after abort", K_R, 1, 0, 1'b0, 1'b0, 32'h10C + 32'h4);

    run_instr("ECALL halt", K_ECALL, 0, 0, 1'b0, 1'b1, 32'h110);
    dut_pcw = 0;
    for (int i = 0; i < 100; i++) cyc("HALT", w_halt(), rb(), 1'b0);
    check("HALT pc_write pulses", 32'(dut_pcw), 32'd0);
    check("HALT pc", pc_m, 32'h110);
    do_reset();
    run_instr("ADD after halt", K_R, 0, 0, 1'b0, 1'b0, 32'h114);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
